// File: rtl/ysyx_22050550_axi_arbiter_fsm_pkg.sv
// Shared encodings for the two-master (IFU/LSU) AXI arbiter in front of one SRAM slave.
package ysyx_22050550_axi_arbiter_fsm_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_22050550_axi_arbiter_fsm_rr_pick.sv
// Two-requester round-robin picker: req[0]=IFU, req[1]=LSU; one-hot grant.
module ysyx_22050550_RrPick
    import ysyx_22050550_axi_arbiter_fsm_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (req == 2'b11) begin
            gnt = (last == OWN_IFU) ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/ysyx_22050550_axi_arbiter_fsm.sv
// Arbitrates IFU and LSU AXI masters onto one SRAM slave with independent read/write FSMs.
module ysyx_22050550_axi_arbiter_fsm
    import ysyx_22050550_axi_arbiter_fsm_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_ifu_Axi_ar_valid,
    input  logic [ADDR_W-1:0] io_ifu_Axi_ar_bits_addr,
    input  logic              io_ifu_Axi_r_ready,
    output logic              io_ifu_Axi_ar_ready,
    output logic              io_ifu_Axi_r_valid,
    output logic [DATA_W-1:0] io_ifu_Axi_r_bits_data,
    output logic [1:0]        io_ifu_Axi_r_rresp,
    output logic              io_ifu_Axi_r_bits_last,
    input  logic              io_ifu_Axi_aw_valid,
    input  logic [ADDR_W-1:0] io_ifu_Axi_aw_bits_addr,
    input  logic              io_ifu_Axi_w_valid,
    input  logic [DATA_W-1:0] io_ifu_Axi_w_bits_data,
    input  logic [STRB_W-1:0] io_ifu_Axi_w_bits_strb,
    input  logic              io_ifu_Axi_b_ready,
    output logic              io_ifu_Axi_aw_ready,
    output logic              io_ifu_Axi_w_ready,
    output logic              io_ifu_Axi_b_valid,
    output logic [1:0]        io_ifu_Axi_b_bits_resp,
    input  logic              io_lsu_Axi_ar_valid,
    input  logic [ADDR_W-1:0] io_lsu_Axi_ar_bits_addr,
    input  logic              io_lsu_Axi_r_ready,
    output logic              io_lsu_Axi_ar_ready,
    output logic              io_lsu_Axi_r_valid,
    output logic [DATA_W-1:0] io_lsu_Axi_r_bits_data,
    output logic [1:0]        io_lsu_Axi_r_rresp,
    output logic              io_lsu_Axi_r_bits_last,
    input  logic              io_lsu_Axi_aw_valid,
    input  logic [ADDR_W-1:0] io_lsu_Axi_aw_bits_addr,
    input  logic              io_lsu_Axi_w_valid,
    input  logic [DATA_W-1:0] io_lsu_Axi_w_bits_data,
    input  logic [STRB_W-1:0] io_lsu_Axi_w_bits_strb,
    input  logic              io_lsu_Axi_b_ready,
    output logic              io_lsu_Axi_aw_ready,
    output logic              io_lsu_Axi_w_ready,
    output logic              io_lsu_Axi_b_valid,
    output logic [1:0]        io_lsu_Axi_b_bits_resp,
    output logic              io_sram_Axi_ar_valid,
    output logic [ADDR_W-1:0] io_sram_Axi_ar_bits_addr,
    output logic              io_sram_Axi_r_ready,
    output logic              io_sram_Axi_aw_valid,
    output logic [ADDR_W-1:0] io_sram_Axi_aw_bits_addr,
    output logic              io_sram_Axi_w_valid,
    output logic [DATA_W-1:0] io_sram_Axi_w_bits_data,
    output logic [STRB_W-1:0] io_sram_Axi_w_bits_strb,
    output logic              io_sram_Axi_b_ready,
    input  logic              io_sram_Axi_ar_ready,
    input  logic              io_sram_Axi_r_valid,
    input  logic [DATA_W-1:0] io_sram_Axi_r_bits_data,
    input  logic [1:0]        io_sram_Axi_r_rresp,
    input  logic              io_sram_Axi_r_bits_last,
    input  logic              io_sram_Axi_aw_ready,
    input  logic              io_sram_Axi_w_ready,
    input  logic              io_sram_Axi_b_valid,
    input  logic [1:0]        io_sram_Axi_b_bits_resp
);

    rd_state_e rd_state_q, rd_state_d;
    wr_state_e wr_state_q, wr_state_d;
    owner_e    rd_own_q, rd_own_d, rd_last_q, rd_last_d;
    owner_e    wr_own_q, wr_own_d, wr_last_q, wr_last_d;
    logic      aw_done_q, aw_done_d, w_done_q, w_done_d;

    logic [1:0] rd_req, rd_gnt, wr_req, wr_gnt;
    logic       live;

    logic              own_ar_valid, own_r_ready;
    logic [ADDR_W-1:0] own_ar_addr;
    logic              own_aw_valid, own_w_valid, own_b_ready;
    logic [ADDR_W-1:0] own_aw_addr;
    logic [DATA_W-1:0] own_w_data;
    logic [STRB_W-1:0] own_w_strb;
    logic              aw_hs, w_hs;

    // Outputs are also forced low while reset is being sampled, not only after it.
    assign live   = !reset;
    assign rd_req = {io_lsu_Axi_ar_valid, io_ifu_Axi_ar_valid};
    assign wr_req = {io_lsu_Axi_aw_valid | io_lsu_Axi_w_valid,
                     io_ifu_Axi_aw_valid | io_ifu_Axi_w_valid};

    ysyx_22050550_RrPick u_rd_pick (.req(rd_req), .last(rd_last_q), .gnt(rd_gnt));
    ysyx_22050550_RrPick u_wr_pick (.req(wr_req), .last(wr_last_q), .gnt(wr_gnt));

    always_comb begin
        own_ar_valid = (rd_own_q == OWN_LSU) ? io_lsu_Axi_ar_valid     : io_ifu_Axi_ar_valid;
        own_ar_addr  = (rd_own_q == OWN_LSU) ? io_lsu_Axi_ar_bits_addr : io_ifu_Axi_ar_bits_addr;
        own_r_ready  = (rd_own_q == OWN_LSU) ? io_lsu_Axi_r_ready      : io_ifu_Axi_r_ready;
        own_aw_valid = (wr_own_q == OWN_LSU) ? io_lsu_Axi_aw_valid     : io_ifu_Axi_aw_valid;
        own_aw_addr  = (wr_own_q == OWN_LSU) ? io_lsu_Axi_aw_bits_addr : io_ifu_Axi_aw_bits_addr;
        own_w_valid  = (wr_own_q == OWN_LSU) ? io_lsu_Axi_w_valid      : io_ifu_Axi_w_valid;
        own_w_data   = (wr_own_q == OWN_LSU) ? io_lsu_Axi_w_bits_data  : io_ifu_Axi_w_bits_data;
        own_w_strb   = (wr_own_q == OWN_LSU) ? io_lsu_Axi_w_bits_strb  : io_ifu_Axi_w_bits_strb;
        own_b_ready  = (wr_own_q == OWN_LSU) ? io_lsu_Axi_b_ready      : io_ifu_Axi_b_ready;
        aw_hs        = own_aw_valid && !aw_done_q && io_sram_Axi_aw_ready;
        w_hs         = own_w_valid && !w_done_q && io_sram_Axi_w_ready;
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_own_d   = rd_own_q;
        rd_last_d  = rd_last_q;
        case (rd_state_q)
            R_IDLE: if (|rd_req) begin
                rd_own_d   = (rd_gnt == 2'b10) ? OWN_LSU : OWN_IFU;
                rd_last_d  = rd_own_d;
                rd_state_d = R_ADDR;
            end
            R_ADDR: if (own_ar_valid && io_sram_Axi_ar_ready) rd_state_d = R_DATA;
            R_DATA: if (io_sram_Axi_r_valid && own_r_ready && io_sram_Axi_r_bits_last) begin
                rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_own_d   = wr_own_q;
        wr_last_d  = wr_last_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        case (wr_state_q)
            W_IDLE: if (|wr_req) begin
                wr_own_d   = (wr_gnt == 2'b10) ? OWN_LSU : OWN_IFU;
                wr_last_d  = wr_own_d;
                wr_state_d = W_REQ;
            end
            W_REQ: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) wr_state_d = W_RESP;
            end
            W_RESP: if (io_sram_Axi_b_valid && own_b_ready) begin
                aw_done_d  = 1'b0;
                w_done_d   = 1'b0;
                wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_state_q <= R_IDLE;
            wr_state_q <= W_IDLE;
            rd_own_q   <= OWN_IFU;
            rd_last_q  <= OWN_IFU;
            wr_own_q   <= OWN_IFU;
            wr_last_q  <= OWN_IFU;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            rd_own_q   <= rd_own_d;
            rd_last_q  <= rd_last_d;
            wr_own_q   <= wr_own_d;
            wr_last_q  <= wr_last_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    always_comb begin
        io_sram_Axi_ar_valid     = 1'b0;
        io_sram_Axi_ar_bits_addr = '0;
        io_sram_Axi_r_ready      = 1'b0;
        io_ifu_Axi_ar_ready      = 1'b0;
        io_lsu_Axi_ar_ready      = 1'b0;
        io_ifu_Axi_r_valid       = 1'b0;
        io_lsu_Axi_r_valid       = 1'b0;
        io_ifu_Axi_r_bits_data   = '0;
        io_lsu_Axi_r_bits_data   = '0;
        io_ifu_Axi_r_rresp       = '0;
        io_lsu_Axi_r_rresp       = '0;
        io_ifu_Axi_r_bits_last   = 1'b0;
        io_lsu_Axi_r_bits_last   = 1'b0;
        if (live && rd_state_q == R_ADDR) begin
            io_sram_Axi_ar_valid     = own_ar_valid;
            io_sram_Axi_ar_bits_addr = own_ar_addr;
            if (rd_own_q == OWN_LSU) io_lsu_Axi_ar_ready = io_sram_Axi_ar_ready;
            else                     io_ifu_Axi_ar_ready = io_sram_Axi_ar_ready;
        end
        if (live && rd_state_q == R_DATA) begin
            io_sram_Axi_r_ready = own_r_ready;
            if (rd_own_q == OWN_LSU) begin
                io_lsu_Axi_r_valid     = io_sram_Axi_r_valid;
                io_lsu_Axi_r_bits_data = io_sram_Axi_r_bits_data;
                io_lsu_Axi_r_rresp     = io_sram_Axi_r_rresp;
                io_lsu_Axi_r_bits_last = io_sram_Axi_r_bits_last;
            end else begin
                io_ifu_Axi_r_valid     = io_sram_Axi_r_valid;
                io_ifu_Axi_r_bits_data = io_sram_Axi_r_bits_data;
                io_ifu_Axi_r_rresp     = io_sram_Axi_r_rresp;
                io_ifu_Axi_r_bits_last = io_sram_Axi_r_bits_last;
            end
        end
    end

    always_comb begin
        io_sram_Axi_aw_valid     = 1'b0;
        io_sram_Axi_aw_bits_addr = '0;
        io_sram_Axi_w_valid      = 1'b0;
        io_sram_Axi_w_bits_data  = '0;
        io_sram_Axi_w_bits_strb  = '0;
        io_sram_Axi_b_ready      = 1'b0;
        io_ifu_Axi_aw_ready      = 1'b0;
        io_lsu_Axi_aw_ready      = 1'b0;
        io_ifu_Axi_w_ready       = 1'b0;
        io_lsu_Axi_w_ready       = 1'b0;
        io_ifu_Axi_b_valid       = 1'b0;
        io_lsu_Axi_b_valid       = 1'b0;
        io_ifu_Axi_b_bits_resp   = '0;
        io_lsu_Axi_b_bits_resp   = '0;
        if (live && wr_state_q == W_REQ) begin
            if (!aw_done_q) begin
                io_sram_Axi_aw_valid     = own_aw_valid;
                io_sram_Axi_aw_bits_addr = own_aw_addr;
                if (wr_own_q == OWN_LSU) io_lsu_Axi_aw_ready = io_sram_Axi_aw_ready;
                else                     io_ifu_Axi_aw_ready = io_sram_Axi_aw_ready;
            end
            if (!w_done_q) begin
                io_sram_Axi_w_valid     = own_w_valid;
                io_sram_Axi_w_bits_data = own_w_data;
                io_sram_Axi_w_bits_strb = own_w_strb;
                if (wr_own_q == OWN_LSU) io_lsu_Axi_w_ready = io_sram_Axi_w_ready;
                else                     io_ifu_Axi_w_ready = io_sram_Axi_w_ready;
            end
        end
        if (live && wr_state_q == W_RESP) begin
            io_sram_Axi_b_ready = own_b_ready;
            if (wr_own_q == OWN_LSU) begin
                io_lsu_Axi_b_valid     = io_sram_Axi_b_valid;
                io_lsu_Axi_b_bits_resp = io_sram_Axi_b_bits_resp;
            end else begin
                io_ifu_Axi_b_valid     = io_sram_Axi_b_valid;
                io_ifu_Axi_b_bits_resp = io_sram_Axi_b_bits_resp;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050550_axi_arbiter_fsm.sv
// Directed plus randomized bench for the IFU/LSU AXI arbiter against a transaction-level model.
module tb_ysyx_22050550_axi_arbiter_fsm;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        ifu_ar_valid, ifu_r_ready, ifu_ar_ready, ifu_r_valid, ifu_r_last;
    logic [63:0] ifu_ar_addr, ifu_r_data;
    logic [1:0]  ifu_rresp;
    logic        ifu_aw_valid, ifu_w_valid, ifu_b_ready, ifu_aw_ready, ifu_w_ready, ifu_b_valid;
    logic [63:0] ifu_aw_addr, ifu_w_data;
    logic [7:0]  ifu_w_strb;
    logic [1:0]  ifu_b_resp;
    logic        lsu_ar_valid, lsu_r_ready, lsu_ar_ready, lsu_r_valid, lsu_r_last;
    logic [63:0] lsu_ar_addr, lsu_r_data;
    logic [1:0]  lsu_rresp;
    logic        lsu_aw_valid, lsu_w_valid, lsu_b_ready, lsu_aw_ready, lsu_w_ready, lsu_b_valid;
    logic [63:0] lsu_aw_addr, lsu_w_data;
    logic [7:0]  lsu_w_strb;
    logic [1:0]  lsu_b_resp;
    logic        s_ar_valid, s_r_ready, s_aw_valid, s_w_valid, s_b_ready;
    logic [63:0] s_ar_addr, s_aw_addr, s_w_data;
    logic [7:0]  s_w_strb;
    logic        s_ar_ready, s_r_valid, s_r_last, s_aw_ready, s_w_ready, s_b_valid;
    logic [63:0] s_r_data;
    logic [1:0]  s_rresp, s_b_resp;

    int unsigned checks = 0;
    int unsigned errors = 0;
    bit rd_last_lsu = 1'b0;
    bit wr_last_lsu = 1'b0;

    ysyx_22050550_axi_arbiter_fsm #(.ADDR_W(64), .DATA_W(64), .STRB_W(8)) dut (
        .clock(clock), .reset(reset),
        .io_ifu_Axi_ar_valid(ifu_ar_valid), .io_ifu_Axi_ar_bits_addr(ifu_ar_addr),
        .io_ifu_Axi_r_ready(ifu_r_ready), .io_ifu_Axi_ar_ready(ifu_ar_ready),
        .io_ifu_Axi_r_valid(ifu_r_valid), .io_ifu_Axi_r_bits_data(ifu_r_data),
        .io_ifu_Axi_r_rresp(ifu_rresp), .io_ifu_Axi_r_bits_last(ifu_r_last),
        .io_ifu_Axi_aw_valid(ifu_aw_valid), .io_ifu_Axi_aw_bits_addr(ifu_aw_addr),
        .io_ifu_Axi_w_valid(ifu_w_valid), .io_ifu_Axi_w_bits_data(ifu_w_data),
        .io_ifu_Axi_w_bits_strb(ifu_w_strb), .io_ifu_Axi_b_ready(ifu_b_ready),
        .io_ifu_Axi_aw_ready(ifu_aw_ready), .io_ifu_Axi_w_ready(ifu_w_ready),
        .io_ifu_Axi_b_valid(ifu_b_valid), .io_ifu_Axi_b_bits_resp(ifu_b_resp),
        .io_lsu_Axi_ar_valid(lsu_ar_valid), .io_lsu_Axi_ar_bits_addr(lsu_ar_addr),
        .io_lsu_Axi_r_ready(lsu_r_ready), .io_lsu_Axi_ar_ready(lsu_ar_ready),
        .io_lsu_Axi_r_valid(lsu_r_valid), .io_lsu_Axi_r_bits_data(lsu_r_data),
        .io_lsu_Axi_r_rresp(lsu_rresp), .io_lsu_Axi_r_bits_last(lsu_r_last),
        .io_lsu_Axi_aw_valid(lsu_aw_valid), .io_lsu_Axi_aw_bits_addr(lsu_aw_addr),
        .io_lsu_Axi_w_valid(lsu_w_valid), .io_lsu_Axi_w_bits_data(lsu_w_data),
        .io_lsu_Axi_w_bits_strb(lsu_w_strb), .io_lsu_Axi_b_ready(lsu_b_ready),
        .io_lsu_Axi_aw_ready(lsu_aw_ready), .io_lsu_Axi_w_ready(lsu_w_ready),
        .io_lsu_Axi_b_valid(lsu_b_valid), .io_lsu_Axi_b_bits_resp(lsu_b_resp),
        .io_sram_Axi_ar_valid(s_ar_valid), .io_sram_Axi_ar_bits_addr(s_ar_addr),
        .io_sram_Axi_r_ready(s_r_ready), .io_sram_Axi_aw_valid(s_aw_valid),
        .io_sram_Axi_aw_bits_addr(s_aw_addr), .io_sram_Axi_w_valid(s_w_valid),
        .io_sram_Axi_w_bits_data(s_w_data), .io_sram_Axi_w_bits_strb(s_w_strb),
        .io_sram_Axi_b_ready(s_b_ready), .io_sram_Axi_ar_ready(s_ar_ready),
        .io_sram_Axi_r_valid(s_r_valid), .io_sram_Axi_r_bits_data(s_r_data),
        .io_sram_Axi_r_rresp(s_rresp), .io_sram_Axi_r_bits_last(s_r_last),
        .io_sram_Axi_aw_ready(s_aw_ready), .io_sram_Axi_w_ready(s_w_ready),
        .io_sram_Axi_b_valid(s_b_valid), .io_sram_Axi_b_bits_resp(s_b_resp)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic m_ar_ready(input bit l); return l ? lsu_ar_ready : ifu_ar_ready; endfunction
    function automatic logic m_r_valid(input bit l);  return l ? lsu_r_valid  : ifu_r_valid;  endfunction
    function automatic logic [63:0] m_r_data(input bit l); return l ? lsu_r_data : ifu_r_data; endfunction
    function automatic logic [1:0] m_rresp(input bit l); return l ? lsu_rresp : ifu_rresp; endfunction
    function automatic logic m_r_last(input bit l);   return l ? lsu_r_last   : ifu_r_last;   endfunction
    function automatic logic m_aw_ready(input bit l); return l ? lsu_aw_ready : ifu_aw_ready; endfunction
    function automatic logic m_w_ready(input bit l);  return l ? lsu_w_ready  : ifu_w_ready;  endfunction
    function automatic logic m_b_valid(input bit l);  return l ? lsu_b_valid  : ifu_b_valid;  endfunction
    function automatic logic [1:0] m_b_resp(input bit l); return l ? lsu_b_resp : ifu_b_resp; endfunction

    task automatic clear_inputs();
        {ifu_ar_valid, ifu_r_ready, ifu_aw_valid, ifu_w_valid, ifu_b_ready} = '0;
        {lsu_ar_valid, lsu_r_ready, lsu_aw_valid, lsu_w_valid, lsu_b_ready} = '0;
        {ifu_ar_addr, ifu_aw_addr, ifu_w_data, lsu_ar_addr, lsu_aw_addr, lsu_w_data} = '0;
        {ifu_w_strb, lsu_w_strb} = '0;
        {s_ar_ready, s_r_valid, s_r_last, s_aw_ready, s_w_ready, s_b_valid} = '0;
        s_r_data = '0;
        {s_rresp, s_b_resp} = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ifu_ar_valid = 1'b1; lsu_aw_valid = 1'b1; s_ar_ready = 1'b1;
        s_r_valid = 1'b1; s_b_valid = 1'b1; ifu_r_ready = 1'b1; lsu_b_ready = 1'b1;
        #1;
        chk("rst_sram_ar_valid", s_ar_valid, 0);
        chk("rst_sram_aw_valid", s_aw_valid, 0);
        chk("rst_sram_r_ready", s_r_ready, 0);
        chk("rst_ifu_r_valid", ifu_r_valid, 0);
        chk("rst_lsu_b_valid", lsu_b_valid, 0);
        step();
        step();
        reset = 1'b0;
        clear_inputs();
        rd_last_lsu = 1'b0;
        wr_last_lsu = 1'b0;
    endtask

    task automatic do_read(input bit rq_i, input bit rq_l, input logic [63:0] a_i,
                           input logic [63:0] a_l, input int unsigned beats, input logic [63:0] d0);
        bit own_l;
        logic [63:0] a_own, d;
        logic [1:0] rr;
        int unsigned stall;
        own_l = (rq_i && rq_l) ? !rd_last_lsu : rq_l;
        rd_last_lsu = own_l;
        a_own = own_l ? a_l : a_i;
        ifu_ar_valid = rq_i; ifu_ar_addr = a_i;
        lsu_ar_valid = rq_l; lsu_ar_addr = a_l;
        s_ar_ready = 1'b1;
        #1;
        chk("rd_decide_sram_ar_valid", s_ar_valid, 0);
        chk("rd_decide_ifu_ar_ready", ifu_ar_ready, 0);
        chk("rd_decide_lsu_ar_ready", lsu_ar_ready, 0);
        step();
        stall = $urandom_range(0, 2);
        for (int unsigned c = 0; c <= stall; c++) begin
            s_ar_ready = (c == stall);
            #1;
            chk("rd_sram_ar_valid", s_ar_valid, 1);
            chk("rd_sram_ar_addr", s_ar_addr, a_own);
            chk("rd_owner_ar_ready", m_ar_ready(own_l), c == stall);
            chk("rd_other_ar_ready", m_ar_ready(!own_l), 0);
            step();
        end
        if (own_l) begin lsu_ar_valid = 1'b0; lsu_r_ready = 1'b1; end
        else       begin ifu_ar_valid = 1'b0; ifu_r_ready = 1'b1; end
        s_ar_ready = 1'b0;
        for (int unsigned b = 0; b < beats; b++) begin
            if ($urandom_range(0, 1) == 1) begin
                s_r_valid = 1'b0;
                #1;
                chk("rd_gap_owner_r_valid", m_r_valid(own_l), 0);
                chk("rd_gap_sram_r_ready", s_r_ready, 1);
                step();
            end
            d  = (b == 0) ? d0 : rnd64();
            rr = 2'($urandom_range(0, 3));
            s_r_valid = 1'b1; s_r_data = d; s_rresp = rr; s_r_last = (b == beats - 1);
            #1;
            chk("rd_owner_r_valid", m_r_valid(own_l), 1);
            chk("rd_owner_r_data", m_r_data(own_l), d);
            chk("rd_owner_rresp", m_rresp(own_l), rr);
            chk("rd_owner_r_last", m_r_last(own_l), b == beats - 1);
            chk("rd_other_r_valid", m_r_valid(!own_l), 0);
            chk("rd_other_ar_ready", m_ar_ready(!own_l), 0);
            chk("rd_data_sram_ar_valid", s_ar_valid, 0);
            step();
        end
        s_r_valid = 1'b0; s_r_last = 1'b0;
        ifu_ar_valid = 1'b0; lsu_ar_valid = 1'b0; ifu_r_ready = 1'b0; lsu_r_ready = 1'b0;
    endtask

    task automatic do_write(input bit rq_i, input bit rq_l, input int unsigned aw_dly,
                            input int unsigned w_dly, input logic [1:0] resp);
        bit own_l, aw_done, w_done;
        logic [63:0] a_own, d_own;
        logic [7:0] s_own;
        int unsigned n_aw, n_w, cyc;
        own_l = (rq_i && rq_l) ? !wr_last_lsu : rq_l;
        wr_last_lsu = own_l;
        ifu_aw_valid = rq_i; ifu_w_valid = rq_i; ifu_aw_addr = rnd64(); ifu_w_data = rnd64();
        ifu_w_strb = 8'($urandom);
        lsu_aw_valid = rq_l; lsu_w_valid = rq_l; lsu_aw_addr = rnd64(); lsu_w_data = rnd64();
        lsu_w_strb = 8'($urandom);
        a_own = own_l ? lsu_aw_addr : ifu_aw_addr;
        d_own = own_l ? lsu_w_data : ifu_w_data;
        s_own = own_l ? lsu_w_strb : ifu_w_strb;
        s_aw_ready = 1'b1; s_w_ready = 1'b1;
        #1;
        chk("wr_decide_sram_aw_valid", s_aw_valid, 0);
        chk("wr_decide_sram_w_valid", s_w_valid, 0);
        step();
        aw_done = 1'b0; w_done = 1'b0; n_aw = 0; n_w = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 12) begin
            s_aw_ready = (cyc >= aw_dly);
            s_w_ready  = (cyc >= w_dly);
            #1;
            chk("wr_sram_aw_valid", s_aw_valid, !aw_done);
            chk("wr_sram_w_valid", s_w_valid, !w_done);
            if (!aw_done) chk("wr_sram_aw_addr", s_aw_addr, a_own);
            if (!w_done) begin
                chk("wr_sram_w_data", s_w_data, d_own);
                chk("wr_sram_w_strb", s_w_strb, s_own);
            end
            chk("wr_owner_aw_ready", m_aw_ready(own_l), s_aw_ready && !aw_done);
            chk("wr_owner_w_ready", m_w_ready(own_l), s_w_ready && !w_done);
            chk("wr_other_aw_ready", m_aw_ready(!own_l), 0);
            chk("wr_other_w_ready", m_w_ready(!own_l), 0);
            if (s_aw_valid && s_aw_ready) n_aw++;
            if (s_w_valid && s_w_ready) n_w++;
            if (s_aw_ready) aw_done = 1'b1;
            if (s_w_ready) w_done = 1'b1;
            step();
            cyc++;
        end
        {ifu_aw_valid, ifu_w_valid, lsu_aw_valid, lsu_w_valid, s_aw_ready, s_w_ready} = '0;
        s_b_valid = 1'b1; s_b_resp = resp; ifu_b_ready = 1'b1; lsu_b_ready = 1'b1;
        #1;
        chk("wr_owner_b_valid", m_b_valid(own_l), 1);
        chk("wr_owner_b_resp", m_b_resp(own_l), resp);
        chk("wr_other_b_valid", m_b_valid(!own_l), 0);
        chk("wr_sram_b_ready", s_b_ready, 1);
        chk("wr_aw_handshakes", n_aw, 1);
        chk("wr_w_handshakes", n_w, 1);
        step();
        #1;
        chk("wr_idle_owner_b_valid", m_b_valid(own_l), 0);
        s_b_valid = 1'b0; ifu_b_ready = 1'b0; lsu_b_ready = 1'b0;
    endtask

    initial begin
        logic [1:0] rq;
        logic [63:0] ca, cb, cd;
        clear_inputs();
        do_reset();

        // single IFU read, then idle must not forward r
        do_read(1'b1, 1'b0, 64'h8000_0000, 64'h0, 1, 64'h1234);
        s_r_valid = 1'b1; s_r_last = 1'b1;
        #1;
        chk("rd_idle_after_ifu_r_valid", ifu_r_valid, 0);
        s_r_valid = 1'b0; s_r_last = 1'b0;

        do_reset();
        do_read(1'b1, 1'b1, rnd64(), rnd64(), 4, rnd64());
        chk("rr_first_lsu", rd_last_lsu, 1);
        do_read(1'b1, 1'b1, rnd64(), rnd64(), 1, rnd64());
        do_read(1'b1, 1'b1, rnd64(), rnd64(), 2, rnd64());

        do_write(1'b0, 1'b1, 1, 0, 2'b00);
        do_write(1'b1, 1'b1, 0, 0, 2'b01);

        // concurrent IFU read and LSU write
        ca = rnd64(); cb = rnd64(); cd = rnd64();
        ifu_ar_valid = 1'b1; ifu_ar_addr = ca;
        lsu_aw_valid = 1'b1; lsu_w_valid = 1'b1; lsu_aw_addr = cb; lsu_w_data = rnd64();
        rd_last_lsu = 1'b0; wr_last_lsu = 1'b1;
        step();
        #1;
        chk("cc_sram_ar_addr", s_ar_addr, ca);
        chk("cc_sram_aw_addr", s_aw_addr, cb);
        chk("cc_sram_aw_valid", s_aw_valid, 1);
        s_ar_ready = 1'b1; s_aw_ready = 1'b1; s_w_ready = 1'b1;
        step();
        {ifu_ar_valid, lsu_aw_valid, lsu_w_valid, s_ar_ready, s_aw_ready, s_w_ready} = '0;
        s_r_valid = 1'b1; s_r_last = 1'b1; s_r_data = cd; ifu_r_ready = 1'b1;
        s_b_valid = 1'b1; s_b_resp = 2'b00; lsu_b_ready = 1'b1;
        #1;
        chk("cc_ifu_r_data", ifu_r_data, cd);
        chk("cc_lsu_b_valid", lsu_b_valid, 1);
        chk("cc_lsu_r_valid", lsu_r_valid, 0);
        chk("cc_ifu_b_valid", ifu_b_valid, 0);
        step();
        clear_inputs();

        // withdrawn request is not forwarded; grant is held until it returns
        ifu_ar_valid = 1'b1; ifu_ar_addr = 64'h100;
        rd_last_lsu = 1'b0;
        step();
        ifu_ar_valid = 1'b0; lsu_ar_valid = 1'b1; s_ar_ready = 1'b1;
        #1;
        chk("wd_sram_ar_valid", s_ar_valid, 0);
        chk("wd_lsu_ar_ready", lsu_ar_ready, 0);
        step();
        step();
        #1;
        chk("wd_still_sram_ar_valid", s_ar_valid, 0);
        ifu_ar_valid = 1'b1;
        #1;
        chk("wd_resume_sram_ar_valid", s_ar_valid, 1);
        chk("wd_resume_sram_ar_addr", s_ar_addr, 64'h100);
        step();
        ifu_ar_valid = 1'b0; s_ar_ready = 1'b0;
        s_r_valid = 1'b1; s_r_last = 1'b1; ifu_r_ready = 1'b1;
        step();
        clear_inputs();

        for (int i = 0; i < 24; i++) begin
            rq = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1)
                do_read(rq[0], rq[1], rnd64(), rnd64(), $urandom_range(1, 4), rnd64());
            else
                do_write(rq[0], rq[1], $urandom_range(0, 3), $urandom_range(0, 3),
                         2'($urandom_range(0, 3)));
        end

        // reset in the middle of a read data phase
        ifu_ar_valid = 1'b1; ifu_ar_addr = 64'h200; s_ar_ready = 1'b1;
        step();
        step();
        ifu_ar_valid = 1'b0; s_ar_ready = 1'b0;
        s_r_valid = 1'b1; s_r_last = 1'b0; s_r_data = 64'hABCD; ifu_r_ready = 1'b1;
        #1;
        chk("mr_before_ifu_r_valid", ifu_r_valid, 1);
        reset = 1'b1;
        #1;
        chk("mr_during_ifu_r_valid", ifu_r_valid, 0);
        step();
        reset = 1'b0;
        #1;
        chk("mr_after_ifu_r_valid", ifu_r_valid, 0);
        chk("mr_after_sram_r_ready", s_r_ready, 0);
        chk("mr_after_lsu_r_valid", lsu_r_valid, 0);
        step();
        #1;
        chk("mr_later_ifu_r_valid", ifu_r_valid, 0);
        chk("mr_later_ifu_r_data", ifu_r_data, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
